alu_seq: RTL

//  Parametrised, registered successor to the combinational 32-bit ALU.
//  - Keeps the existing control encoding, adds SRLV/SRAV and an iterative unsigned multiply/divide unit.
//  - Uses a start/ready/done handshake.
//  - Sits in the execute stage; the controller stalls while ready=0.

---
 rtl/alu_seq.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// Registered ALU with start/ready/done handshake; single-cycle logic/shift ops plus
// optional iterative unsigned multiply/divide, built only when ALU_MULDIV_EN is defined.
module alu_seq #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       control,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] Y,
  output logic             Zero
);

`ifdef ALU_MULDIV_EN
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
`else
  typedef enum logic {IDLE, DONE} state_t;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] alu_res;
  logic [SHW-1:0]   shamt;

  assign shamt = B[SHW-1:0];

  always_comb begin
    alu_res = '0;
    case (control)
      4'b0000: alu_res = A & B;
      4'b0001: alu_res = A | B;
      4'b0010: alu_res = A + B;
      4'b0110: alu_res = A - B;
      4'b0111: alu_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      4'b1100: alu_res = ~(A | B);
      4'b0100: alu_res = A << shamt;
      4'b0101: alu_res = A >> shamt;
      4'b0011: alu_res = $signed(A) >>> shamt;
      default: alu_res = '0;
    endcase
  end

`ifdef ALU_MULDIV_EN
  // prod_q is the product during multiply and {remainder, quotient} during divide
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [CW-1:0]      count_q, count_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH:0]     mul_sum, div_top, div_diff;
  logic               div_ge;
  logic               is_muldiv;
  logic [WIDTH-1:0]   md_res;

  assign is_muldiv = (control[3:2] == 2'b10);
  assign mul_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, b_q} : '0);
  assign div_top   = prod_q[2*WIDTH-1:WIDTH-1];
  assign div_diff  = div_top - {1'b0, b_q};
  assign div_ge    = (div_top >= {1'b0, b_q});
  assign md_res    = op_q[0] ? prod_q[2*WIDTH-1:WIDTH] : prod_q[WIDTH-1:0];

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    zero_d  = zero_q;
    prod_d  = prod_q;
    count_d = count_q;
    op_d    = op_q;
    b_d     = b_q;
    case (state_q)
      CALC: begin
        if (count_q == CW'(WIDTH)) begin
          y_d     = md_res;
          zero_d  = (md_res == '0);
          state_d = DONE;
        end else begin
          count_d = count_q + CW'(1);
          if (!op_q[1]) begin
            prod_d = {mul_sum, prod_q[WIDTH-1:1]};
          end else if (div_ge) begin
            prod_d = {div_diff[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1};
          end else begin
            prod_d = {div_top[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b0};
          end
        end
      end
      default: begin
        state_d = IDLE;
        if (start) begin
          if (is_muldiv) begin
            op_d    = control[1:0];
            b_d     = B;
            prod_d  = {{WIDTH{1'b0}}, A};
            count_d = '0;
            state_d = CALC;
          end else begin
            y_d     = alu_res;
            zero_d  = (alu_res == '0);
            state_d = DONE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prod_q  <= '0;
      count_q <= '0;
      op_q    <= '0;
      b_q     <= '0;
    end else begin
      prod_q  <= prod_d;
      count_q <= count_d;
      op_q    <= op_d;
      b_q     <= b_d;
    end
  end

  assign ready = (state_q != CALC);
`else
  always_comb begin
    state_d = IDLE;
    y_d     = y_q;
    zero_d  = zero_q;
    if (start) begin
      y_d     = alu_res;
      zero_d  = (alu_res == '0);
      state_d = DONE;
    end
  end

  assign ready = 1'b1;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      y_q     <= '0;
      zero_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      zero_q  <= zero_d;
    end
  end

  assign done = (state_q == DONE);
  assign Y    = y_q;
  assign Zero = zero_q;

endmodule
